// File: rtl/obi_pkg.sv
// Shared constants and helpers for the OBI scratch-memory subordinate.
package obi_pkg;

    // Default geometry of the memory slave.
    localparam int unsigned OBI_DEF_ADDR_WIDTH = 32;
    localparam int unsigned OBI_DEF_DATA_WIDTH = 32;
    localparam int unsigned OBI_DEF_MEM_DEPTH  = 64;
    localparam int unsigned OBI_DEF_RSP_DEPTH  = 2;
    localparam int unsigned OBI_DEF_ID_WIDTH   = 1;

    // Derived widths for the default geometry.
    localparam int unsigned BE_WIDTH  = OBI_DEF_DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH = $clog2(OBI_DEF_MEM_DEPTH);
    localparam int unsigned OFS_WIDTH = $clog2(BE_WIDTH);

    // Number of byte lanes for a given data width.
    function automatic int unsigned obi_be_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Width needed to hold a count from 0 up to and including n.
    function automatic int unsigned obi_cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/obi_rsp_fifo.sv
// Synchronous response FIFO; depth need not be a power of two.
module obi_rsp_fifo
    import obi_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 1,
    localparam int unsigned CNT_W = obi_cnt_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             i_push,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer increment with explicit wrap at DEPTH-1.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr + 1'b1;
        w_rd_ptr_nxt = r_rd_ptr + 1'b1;
        if (r_wr_ptr == PTR_W'(DEPTH - 1)) w_wr_ptr_nxt = '0;
        if (r_rd_ptr == PTR_W'(DEPTH - 1)) w_rd_ptr_nxt = '0;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= w_wr_ptr_nxt;
            if (w_do_pop)  r_rd_ptr <= w_rd_ptr_nxt;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    // Entry storage; contents are qualified by the count so need no reset.
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/obi_mem_slave_pipe.sv
// OBI subordinate backed by a byte-addressable flop-array memory.
module obi_mem_slave_pipe
    import obi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = OBI_DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = OBI_DEF_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH  = OBI_DEF_MEM_DEPTH,
    parameter int unsigned RSP_DEPTH  = OBI_DEF_RSP_DEPTH,
    parameter int unsigned ID_WIDTH   = OBI_DEF_ID_WIDTH,
    parameter bit          GNT_BYPASS = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      obi_req_i,
    output logic                      obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]     obi_addr_i,
    input  logic                      obi_we_i,
    input  logic [DATA_WIDTH/8-1:0]   obi_be_i,
    input  logic [DATA_WIDTH-1:0]     obi_wdata_i,
    input  logic [ID_WIDTH-1:0]       obi_aid_i,
    output logic                      obi_rvalid_o,
    input  logic                      obi_rready_i,
    output logic [DATA_WIDTH-1:0]     obi_rdata_o,
    output logic                      obi_err_o,
    output logic [ID_WIDTH-1:0]       obi_rid_o
);

    localparam int unsigned M_BE_WIDTH  = obi_be_width(DATA_WIDTH);
    localparam int unsigned M_IDX_WIDTH = $clog2(MEM_DEPTH);
    localparam int unsigned M_OFS_WIDTH = $clog2(M_BE_WIDTH);
    localparam int unsigned M_DEC_WIDTH = M_OFS_WIDTH + M_IDX_WIDTH;
    localparam int unsigned M_CNT_W     = obi_cnt_width(RSP_DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
        logic [ID_WIDTH-1:0]   rid;
    } obi_rsp_t;

    localparam int unsigned M_RSP_WIDTH = $bits(obi_rsp_t);

    logic [DATA_WIDTH-1:0]  r_mem [MEM_DEPTH];
    logic [M_IDX_WIDTH-1:0] w_idx;
    logic                   w_oor;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_wr_en;
    logic                   w_full;
    logic                   w_empty;
    logic [M_CNT_W-1:0]     w_count;
    logic                   w_gnt;
    logic                   w_rvalid;
    obi_rsp_t               w_rsp_in;
    obi_rsp_t               w_rsp_out;
    logic                   w_unused_ok;

    assign w_idx = obi_addr_i[M_OFS_WIDTH +: M_IDX_WIDTH];

    // Byte-lane address bits play no part in word selection.
    assign w_unused_ok = ^obi_addr_i[M_OFS_WIDTH-1:0];

    // Any set bit above the word index falls outside the memory.
    if (ADDR_WIDTH > M_DEC_WIDTH) begin : g_oor
        assign w_oor = |obi_addr_i[ADDR_WIDTH-1:M_DEC_WIDTH];
    end else begin : g_no_oor
        assign w_oor = 1'b0;
    end

    assign w_rvalid = (w_count != '0);
    assign w_pop    = w_rvalid && obi_rready_i;
    assign w_gnt    = !w_full || (GNT_BYPASS && w_pop);
    assign w_push   = obi_req_i && w_gnt;
    assign w_wr_en  = w_push && obi_we_i && !w_oor;

    assign obi_gnt_o = w_gnt;

    // Build the response for the request being accepted this cycle.
    always_comb begin
        w_rsp_in.rdata = '0;
        w_rsp_in.err   = w_oor;
        w_rsp_in.rid   = obi_aid_i;
        if (!obi_we_i && !w_oor) w_rsp_in.rdata = r_mem[w_idx];
    end

    // Byte-masked write of an accepted in-range request; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int unsigned i = 0; i < M_BE_WIDTH; i++) begin
                if (obi_be_i[i]) r_mem[w_idx][8*i +: 8] <= obi_wdata_i[8*i +: 8];
            end
        end
    end

    obi_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (M_RSP_WIDTH)
    ) u_rsp_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (w_count),
        .i_din    (w_rsp_in),
        .o_dout   (w_rsp_out)
    );

    // R-channel fields read as zero whenever no response is held.
    always_comb begin
        obi_rvalid_o = w_rvalid;
        obi_rdata_o  = '0;
        obi_err_o    = 1'b0;
        obi_rid_o    = '0;
        if (!w_empty) begin
            obi_rdata_o = w_rsp_out.rdata;
            obi_err_o   = w_rsp_out.err;
            obi_rid_o   = w_rsp_out.rid;
        end
    end

endmodule

// File: tb/tb_obi_mem_slave_pipe.sv
// Directed and randomized checks of obi_mem_slave_pipe against a queue/array model.
module tb_obi_mem_slave_pipe;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned MD  = 64;
    localparam int unsigned RD  = 2;
    localparam int unsigned IW  = 1;
    localparam bit          BYP = 1'b0;

    logic          clk_i;
    logic          reset_ni;
    logic          obi_req_i;
    logic          obi_gnt_o;
    logic [AW-1:0] obi_addr_i;
    logic          obi_we_i;
    logic [3:0]    obi_be_i;
    logic [DW-1:0] obi_wdata_i;
    logic [IW-1:0] obi_aid_i;
    logic          obi_rvalid_o;
    logic          obi_rready_i;
    logic [DW-1:0] obi_rdata_o;
    logic          obi_err_o;
    logic [IW-1:0] obi_rid_o;

    obi_mem_slave_pipe #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (MD),
        .RSP_DEPTH  (RD),
        .ID_WIDTH   (IW),
        .GNT_BYPASS (BYP)
    ) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .obi_req_i    (obi_req_i),
        .obi_gnt_o    (obi_gnt_o),
        .obi_addr_i   (obi_addr_i),
        .obi_we_i     (obi_we_i),
        .obi_be_i     (obi_be_i),
        .obi_wdata_i  (obi_wdata_i),
        .obi_aid_i    (obi_aid_i),
        .obi_rvalid_o (obi_rvalid_o),
        .obi_rready_i (obi_rready_i),
        .obi_rdata_o  (obi_rdata_o),
        .obi_err_o    (obi_err_o),
        .obi_rid_o    (obi_rid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        id;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mem_m [MD];
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    logic        o_gnt;
    logic        o_rvalid;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_rid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at negedge, check outputs, then advance the model past posedge.
    task automatic step(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input logic aid, input logic rready);
        logic        exp_gnt;
        logic        hs;
        logic        oor;
        int unsigned idx;
        rsp_t        r;
        @(negedge clk_i);
        obi_req_i    = req;
        obi_we_i     = we;
        obi_addr_i   = addr;
        obi_be_i     = be;
        obi_wdata_i  = wdata;
        obi_aid_i    = aid;
        obi_rready_i = rready;
        #1;
        exp_gnt = (q.size() < RD) || (BYP && q.size() != 0 && rready);
        check("gnt", 64'(obi_gnt_o), 64'(exp_gnt));
        check("rvalid", 64'(obi_rvalid_o), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("rdata", 64'(obi_rdata_o), 64'(q[0].data));
            check("err", 64'(obi_err_o), 64'(q[0].err));
            check("rid", 64'(obi_rid_o), 64'(q[0].id));
        end
        o_gnt    = obi_gnt_o;
        o_rvalid = obi_rvalid_o;
        o_rdata  = obi_rdata_o;
        o_err    = obi_err_o;
        o_rid    = obi_rid_o;
        hs = req && exp_gnt;
        @(posedge clk_i);
        if (q.size() != 0 && rready) void'(q.pop_front());
        if (hs) begin
            oor    = |addr[31:8];
            idx    = int'(addr[7:2]);
            r.err  = oor;
            r.id   = aid;
            r.data = (!we && !oor) ? mem_m[idx] : 32'h0;
            q.push_back(r);
            if (we && !oor) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    endtask

    task automatic idle(input logic rready);
        step(1'b0, 1'bx, 'x, 'x, 'x, 1'b0, rready);
    endtask

    initial begin
        reset_ni     = 1'b0;
        obi_req_i    = 1'b0;
        obi_we_i     = 1'bx;
        obi_addr_i   = 'x;
        obi_be_i     = 'x;
        obi_wdata_i  = 'x;
        obi_aid_i    = '0;
        obi_rready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
        #1;
        check("rst_gnt", 64'(obi_gnt_o), 64'd1);
        check("rst_rvalid", 64'(obi_rvalid_o), 64'd0);
        check("rst_rdata", 64'(obi_rdata_o), 64'd0);
        check("rst_err", 64'(obi_err_o), 64'd0);
        check("rst_rid", 64'(obi_rid_o), 64'd0);

        // Give every word a known value.
        for (int i = 0; i < int'(MD); i++) step(1'b1, 1'b1, 32'(i * 4), 4'hF, $urandom, 1'b0, 1'b1);
        idle(1'b1);

        // Full write then read of the same word back to back.
        step(1'b1, 1'b1, 32'h08, 4'hF, 32'hDEADBEEF, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'h08, 4'h0, 32'h0, 1'b0, 1'b1);
        check("wr_rsp_rvalid", 64'(o_rvalid), 64'd1);
        check("wr_rsp_err", 64'(o_err), 64'd0);
        check("wr_rsp_rid", 64'(o_rid), 64'd1);
        idle(1'b1);
        check("rd_rsp_rdata", 64'(o_rdata), 64'hDEADBEEF);
        check("rd_rsp_rid", 64'(o_rid), 64'd0);

        // Partial byte enables, then an empty byte mask.
        step(1'b1, 1'b1, 32'h08, 4'b0101, 32'h11223344, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'h0B, 4'h0, 32'h0, 1'b0, 1'b1);
        idle(1'b1);
        check("be_rdata", 64'(o_rdata), 64'hDE22BE44);
        step(1'b1, 1'b1, 32'h08, 4'b0000, 32'hFFFFFFFF, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'h08, 4'h0, 32'h0, 1'b0, 1'b1);
        idle(1'b1);
        check("be0_rdata", 64'(o_rdata), 64'hDE22BE44);

        // Out-of-range accesses alias word 0 in the low bits but must not touch it.
        step(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h100, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b1);
        check("oor_rd_err", 64'(o_err), 64'd1);
        check("oor_rd_rdata", 64'(o_rdata), 64'd0);
        step(1'b1, 1'b0, 32'h000, 4'h0, 32'h0, 1'b1, 1'b1);
        check("oor_wr_err", 64'(o_err), 64'd1);
        idle(1'b1);
        check("mem0_intact", 64'(o_rdata), 64'(mem_m[0]));

        // Backpressure with a held request.
        step(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0);
        check("bp_gnt1", 64'(o_gnt), 64'd1);
        step(1'b1, 1'b0, 32'h14, 4'h0, 32'h0, 1'b1, 1'b0);
        check("bp_gnt2", 64'(o_gnt), 64'd1);
        step(1'b1, 1'b0, 32'h18, 4'h0, 32'h0, 1'b0, 1'b0);
        check("bp_gnt3", 64'(o_gnt), 64'd0);
        step(1'b1, 1'b0, 32'h18, 4'h0, 32'h0, 1'b0, 1'b1);
        check("bp_gnt_pop", 64'(o_gnt), 64'(BYP));
        check("bp_first_rid", 64'(o_rid), 64'd0);
        if (!BYP) step(1'b1, 1'b0, 32'h18, 4'h0, 32'h0, 1'b0, 1'b1);
        repeat (3) idle(1'b1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = {24'h0, 6'($urandom_range(0, MD - 1)), 2'($urandom)};
            if ($urandom_range(0, 7) == 0) a = {24'($urandom_range(1, 24'hFFFFFF)), 8'($urandom)};
            step($urandom_range(0, 3) != 0, 1'($urandom), a, 4'($urandom), $urandom,
                 1'($urandom), $urandom_range(0, 3) != 0);
        end
        repeat (4) idle(1'b1);

        // Reset while two responses are pending.
        step(1'b1, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 1'b1, 1'b1);
        idle(1'b1);
        step(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h24, 4'hF, 32'h12345678, 1'b1, 1'b0);
        #2;
        obi_req_i = 1'b0;
        reset_ni  = 1'b0;
        #1;
        check("midrst_rvalid", 64'(obi_rvalid_o), 64'd0);
        q.delete();
        @(negedge clk_i);
        reset_ni = 1'b1;
        #1;
        check("midrst_gnt", 64'(obi_gnt_o), 64'd1);
        check("midrst_rvalid_rel", 64'(obi_rvalid_o), 64'd0);
        step(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'h24, 4'h0, 32'h0, 1'b1, 1'b1);
        check("midrst_rd20", 64'(o_rdata), 64'hCAFEF00D);
        idle(1'b1);
        check("midrst_rd24", 64'(o_rdata), 64'h12345678);
        idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
